// File: rtl/diff_pkg.sv
// Shared types for the difftest commit scheduler: one buffered commit record
// and the store test used by the drain logic.
package diff_pkg;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned DATA_W = 64;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [31:0]       instr;
        logic              wen;
        logic [7:0]        wdest;
        logic [DATA_W-1:0] wdata;
        logic [7:0]        st_valid;
        logic [PC_W-1:0]   st_paddr;
        logic [PC_W-1:0]   st_vaddr;
        logic [DATA_W-1:0] st_data;
    } commit_rec_t;

    function automatic logic is_store(input commit_rec_t rec);
        return |rec.st_valid;
    endfunction

endpackage

// File: rtl/diff_commit_sched_if.sv
// Commit-side and difftest-side signals of the commit scheduler, flattened per lane/slot.
interface diff_commit_sched_if #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 4
);
    logic [IN_W-1:0]                    in_valid;
    logic                               in_ready;
    logic [IN_W*diff_pkg::PC_W-1:0]     in_pc;
    logic [IN_W*32-1:0]                 in_instr;
    logic [IN_W-1:0]                    in_wen;
    logic [IN_W*8-1:0]                  in_wdest;
    logic [IN_W*diff_pkg::DATA_W-1:0]   in_wdata;
    logic [IN_W*8-1:0]                  in_st_valid;
    logic [IN_W*diff_pkg::PC_W-1:0]     in_st_paddr;
    logic [IN_W*diff_pkg::PC_W-1:0]     in_st_vaddr;
    logic [IN_W*diff_pkg::DATA_W-1:0]   in_st_data;

    logic [OUT_W-1:0]                   out_valid;
    logic [OUT_W*diff_pkg::PC_W-1:0]    out_pc;
    logic [OUT_W*32-1:0]                out_instr;
    logic [OUT_W-1:0]                   out_wen;
    logic [OUT_W*8-1:0]                 out_wdest;
    logic [OUT_W*diff_pkg::DATA_W-1:0]  out_wdata;
    logic [7:0]                         st_valid;
    logic [diff_pkg::PC_W-1:0]          st_paddr;
    logic [diff_pkg::PC_W-1:0]          st_vaddr;
    logic [diff_pkg::DATA_W-1:0]        st_data;
    logic [63:0]                        commit_cnt;

    modport master (
        output in_valid, in_pc, in_instr, in_wen, in_wdest, in_wdata,
               in_st_valid, in_st_paddr, in_st_vaddr, in_st_data,
        input  in_ready, out_valid, out_pc, out_instr, out_wen, out_wdest, out_wdata,
               st_valid, st_paddr, st_vaddr, st_data, commit_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_wen, in_wdest, in_wdata,
               in_st_valid, in_st_paddr, in_st_vaddr, in_st_data,
        output in_ready, out_valid, out_pc, out_instr, out_wen, out_wdest, out_wdata,
               st_valid, st_paddr, st_vaddr, st_data, commit_cnt
    );

endinterface

// File: rtl/diff_commit_fifo.sv
// Circular record buffer: up to IN_W compacted writes at tail and an OUT_W-entry
// read window at head, retired by pop_n entries per cycle.
module diff_commit_fifo
    import diff_pkg::*;
#(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 4,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned NW   = $clog2(OUT_W + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [IN_W-1:0]         push,
    input  commit_rec_t [IN_W-1:0]  push_rec,
    input  logic [NW-1:0]           pop_n,
    output logic [CW-1:0]           count,
    output commit_rec_t [OUT_W-1:0] window
);

    commit_rec_t   mem [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] push_cnt;

    always_comb begin
        push_cnt = '0;
        for (int k = 0; k < IN_W; k++) begin
            push_cnt = push_cnt + CW'(push[k]);
        end
    end

    // push is compacted, so valid entry k always lands at tail+k
    always_ff @(posedge clock) begin
        for (int k = 0; k < IN_W; k++) begin
            if (push[k]) begin
                mem[tail_q + AW'(k)] <= push_rec[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + AW'(pop_n);
            tail_q  <= tail_q + AW'(push_cnt);
            count_q <= count_q + push_cnt - CW'(pop_n);
        end
    end

    always_comb begin
        for (int k = 0; k < OUT_W; k++) begin
            window[k] = mem[head_q + AW'(k)];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/diff_commit_sched.sv
// Schedules buffered commit records onto OUT_W difftest slots in program order,
// ending each cycle's group at the first store so the single StoreEvent port suffices.
module diff_commit_sched
    import diff_pkg::*;
#(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    diff_commit_sched_if.slave io
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned NW = $clog2(OUT_W + 1);

    logic                    in_ready;
    commit_rec_t [IN_W-1:0]  lane_rec;
    commit_rec_t [IN_W-1:0]  push_rec;
    logic        [IN_W-1:0]  push;
    logic        [CW-1:0]    count;
    commit_rec_t [OUT_W-1:0] window;
    logic        [NW-1:0]    drain_n;
    logic                    drain_st;
    commit_rec_t             st_rec;

    logic [OUT_W-1:0]              out_valid_q;
    logic [OUT_W-1:0][PC_W-1:0]    out_pc_q;
    logic [OUT_W-1:0][31:0]        out_instr_q;
    logic [OUT_W-1:0]              out_wen_q;
    logic [OUT_W-1:0][7:0]         out_wdest_q;
    logic [OUT_W-1:0][DATA_W-1:0]  out_wdata_q;
    logic [7:0]                    st_valid_q;
    logic [PC_W-1:0]               st_paddr_q;
    logic [PC_W-1:0]               st_vaddr_q;
    logic [DATA_W-1:0]             st_data_q;
    logic [63:0]                   commit_cnt_q;

    assign in_ready = (DEPTH - 32'(count)) >= IN_W;

    always_comb begin
        for (int k = 0; k < IN_W; k++) begin
            lane_rec[k].pc       = io.in_pc[PC_W*k +: PC_W];
            lane_rec[k].instr    = io.in_instr[32*k +: 32];
            lane_rec[k].wen      = io.in_wen[k];
            lane_rec[k].wdest    = io.in_wdest[8*k +: 8];
            lane_rec[k].wdata    = io.in_wdata[DATA_W*k +: DATA_W];
            lane_rec[k].st_valid = io.in_st_valid[8*k +: 8];
            lane_rec[k].st_paddr = io.in_st_paddr[PC_W*k +: PC_W];
            lane_rec[k].st_vaddr = io.in_st_vaddr[PC_W*k +: PC_W];
            lane_rec[k].st_data  = io.in_st_data[DATA_W*k +: DATA_W];
        end
    end

    // Pack accepted lanes towards slot 0 so the buffer writes a dense run at tail
    always_comb begin
        int slot;
        push     = '0;
        push_rec = '0;
        slot     = 0;
        for (int k = 0; k < IN_W; k++) begin
            if (io.in_valid[k] && in_ready) begin
                for (int j = 0; j < IN_W; j++) begin
                    if (j == slot) begin
                        push[j]     = 1'b1;
                        push_rec[j] = lane_rec[k];
                    end
                end
                slot++;
            end
        end
    end

    diff_commit_fifo #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_rec (push_rec),
        .pop_n    (drain_n),
        .count    (count),
        .window   (window)
    );

    // Group size: stop after the first store in the window, never past the live entries
    always_comb begin
        int n;
        int first_st;
        first_st = int'(OUT_W);
        for (int k = int'(OUT_W) - 1; k >= 0; k--) begin
            if (is_store(window[k])) first_st = k;
        end
        n = int'(OUT_W);
        if (int'(count) < n) n = int'(count);
        if (first_st + 1 < n) n = first_st + 1;
        drain_n  = NW'(n);
        drain_st = 1'b0;
        st_rec   = '0;
        for (int k = 0; k < OUT_W; k++) begin
            if (k == n - 1 && is_store(window[k])) begin
                drain_st = 1'b1;
                st_rec   = window[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= '0;
            out_pc_q     <= '0;
            out_instr_q  <= '0;
            out_wen_q    <= '0;
            out_wdest_q  <= '0;
            out_wdata_q  <= '0;
            st_valid_q   <= '0;
            st_paddr_q   <= '0;
            st_vaddr_q   <= '0;
            st_data_q    <= '0;
            commit_cnt_q <= '0;
        end else begin
            for (int k = 0; k < OUT_W; k++) begin
                if (k < int'(drain_n)) begin
                    out_valid_q[k] <= 1'b1;
                    out_pc_q[k]    <= window[k].pc;
                    out_instr_q[k] <= window[k].instr;
                    out_wen_q[k]   <= window[k].wen;
                    out_wdest_q[k] <= window[k].wdest;
                    out_wdata_q[k] <= window[k].wdata;
                end else begin
                    out_valid_q[k] <= 1'b0;
                    out_pc_q[k]    <= '0;
                    out_instr_q[k] <= '0;
                    out_wen_q[k]   <= 1'b0;
                    out_wdest_q[k] <= '0;
                    out_wdata_q[k] <= '0;
                end
            end
            if (drain_st) begin
                st_valid_q <= st_rec.st_valid;
                st_paddr_q <= st_rec.st_paddr;
                st_vaddr_q <= st_rec.st_vaddr;
                st_data_q  <= st_rec.st_data;
            end else begin
                st_valid_q <= '0;
                st_paddr_q <= '0;
                st_vaddr_q <= '0;
                st_data_q  <= '0;
            end
            commit_cnt_q <= commit_cnt_q + 64'(drain_n);
        end
    end

    assign io.in_ready   = in_ready;
    assign io.out_valid  = out_valid_q;
    assign io.out_pc     = out_pc_q;
    assign io.out_instr  = out_instr_q;
    assign io.out_wen    = out_wen_q;
    assign io.out_wdest  = out_wdest_q;
    assign io.out_wdata  = out_wdata_q;
    assign io.st_valid   = st_valid_q;
    assign io.st_paddr   = st_paddr_q;
    assign io.st_vaddr   = st_vaddr_q;
    assign io.st_data    = st_data_q;
    assign io.commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_diff_commit_sched.sv
// Scoreboard bench for diff_commit_sched: a queue-based reference buffer predicts each
// cycle's commit group; a monitor compares whenever the DUT presents slots.
module tb_diff_commit_sched;
    import diff_pkg::*;

    localparam int IN_W  = 2;
    localparam int OUT_W = 4;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0]             cyc;
        logic [63:0]             cnt;
        logic [3:0]              n;
        commit_rec_t [OUT_W-1:0] recs;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    diff_commit_sched_if #(.IN_W(IN_W), .OUT_W(OUT_W)) io ();

    diff_commit_sched #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    commit_rec_t model_q[$];
    exp_t        exp_q[$];
    logic [63:0] model_cnt = '0;
    logic [63:0] pc_next   = 64'h1c00_0000;
    logic        saw_not_ready;

    function automatic void chk(input string name, input logic [255:0] act,
                                input logic [255:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endfunction

    function automatic commit_rec_t mk(input logic st, input logic [63:0] paddr);
        commit_rec_t r;
        r.pc     = pc_next;
        pc_next  = pc_next + 64'd4;
        r.instr  = $urandom;
        r.wen    = 1'($urandom);
        r.wdest  = 8'($urandom);
        r.wdata  = {$urandom, $urandom};
        if (st) begin
            r.st_valid = 8'($urandom_range(1, 255));
            r.st_paddr = paddr;
            r.st_vaddr = {$urandom, $urandom};
            r.st_data  = {$urandom, $urandom};
        end else begin
            r.st_valid = '0;
            r.st_paddr = '0;
            r.st_vaddr = '0;
            r.st_data  = '0;
        end
        return r;
    endfunction

    // One clock of stimulus; the reference model advances by the same edge.
    task automatic step(input int nl, input commit_rec_t r0, input commit_rec_t r1);
        commit_rec_t lanes[IN_W];
        exp_t        e;
        int          n;
        logic        ready_m;
        @(negedge clock);
        lanes[0] = r0;
        lanes[1] = r1;
        ready_m  = (DEPTH - model_q.size()) >= IN_W;
        chk("in_ready", 256'(io.in_ready), 256'(ready_m));
        if (!io.in_ready) saw_not_ready = 1'b1;
        if (!ready_m) nl = 0;
        for (int i = 0; i < IN_W; i++) begin
            io.in_valid[i]             = (i < nl);
            io.in_pc[64*i +: 64]       = lanes[i].pc;
            io.in_instr[32*i +: 32]    = lanes[i].instr;
            io.in_wen[i]               = lanes[i].wen;
            io.in_wdest[8*i +: 8]      = lanes[i].wdest;
            io.in_wdata[64*i +: 64]    = lanes[i].wdata;
            io.in_st_valid[8*i +: 8]   = lanes[i].st_valid;
            io.in_st_paddr[64*i +: 64] = lanes[i].st_paddr;
            io.in_st_vaddr[64*i +: 64] = lanes[i].st_vaddr;
            io.in_st_data[64*i +: 64]  = lanes[i].st_data;
        end
        // Take records in order, up to OUT_W, and stop right after a store
        n = 0;
        while (n < OUT_W && n < model_q.size()) begin
            n++;
            if (is_store(model_q[n-1])) break;
        end
        if (n > 0) begin
            e = '0;
            e.n = 4'(n);
            for (int k = 0; k < n; k++) e.recs[k] = model_q.pop_front();
            model_cnt = model_cnt + 64'(n);
            e.cnt = model_cnt;
            e.cyc = 32'(cyc + 1);
            exp_q.push_back(e);
        end
        for (int i = 0; i < nl; i++) model_q.push_back(lanes[i]);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, '0, '0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset       = 1'b1;
        io.in_valid = '0;
        model_q.delete();
        model_cnt   = '0;
        repeat (cycles) @(negedge clock);
        chk("rst_out_valid", 256'(io.out_valid), 256'(0));
        chk("rst_st_valid", 256'(io.st_valid), 256'(0));
        chk("rst_commit_cnt", 256'(io.commit_cnt), 256'(0));
        chk("rst_in_ready", 256'(io.in_ready), 256'(1));
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a commit group
    initial begin
        exp_t             e;
        logic [OUT_W-1:0] ev;
        commit_rec_t      r;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (io.out_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 256'(io.out_valid), 256'(0));
                end else begin
                    e  = exp_q.pop_front();
                    ev = '0;
                    for (int k = 0; k < int'(e.n); k++) ev[k] = 1'b1;
                    chk("group_cycle", 256'(cyc), 256'(e.cyc));
                    chk("out_valid", 256'(io.out_valid), 256'(ev));
                    for (int k = 0; k < int'(e.n); k++) begin
                        r = e.recs[k];
                        chk($sformatf("slot%0d", k),
                            256'({io.out_pc[64*k +: 64], io.out_instr[32*k +: 32], io.out_wen[k],
                                  io.out_wdest[8*k +: 8], io.out_wdata[64*k +: 64]}),
                            256'({r.pc, r.instr, r.wen, r.wdest, r.wdata}));
                    end
                    r = e.recs[int'(e.n) - 1];
                    if (is_store(r)) begin
                        chk("store_event",
                            256'({io.st_valid, io.st_paddr, io.st_vaddr, io.st_data}),
                            256'({r.st_valid, r.st_paddr, r.st_vaddr, r.st_data}));
                    end else begin
                        chk("no_store", 256'(io.st_valid), 256'(0));
                    end
                    chk("commit_cnt", 256'(io.commit_cnt), 256'(e.cnt));
                end
            end else begin
                chk("idle_st", 256'(io.st_valid), 256'(0));
            end
        end
    end

    initial begin
        io.in_valid    = '0;
        io.in_pc       = '0;
        io.in_instr    = '0;
        io.in_wen      = '0;
        io.in_wdest    = '0;
        io.in_wdata    = '0;
        io.in_st_valid = '0;
        io.in_st_paddr = '0;
        io.in_st_vaddr = '0;
        io.in_st_data  = '0;
        saw_not_ready  = 1'b0;

        do_reset(3);

        // Two ALU lanes for four cycles
        for (int i = 0; i < 4; i++) step(2, mk(0, '0), mk(0, '0));
        idle(3);
        chk("cnt_after_alu", 256'(io.commit_cnt), 256'(8));

        // Back-to-back stores, then ALU, ALU, ST, ALU, ALU queued behind them
        step(2, mk(1, 64'h100), mk(1, 64'h104));
        step(2, mk(1, 64'h108), mk(0, '0));
        step(2, mk(0, '0), mk(1, 64'h200));
        step(2, mk(0, '0), mk(0, '0));
        idle(6);

        // Two stores per cycle fill the buffer until in_ready drops
        saw_not_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(2, mk(1, 64'h1000 + 64'(16 * i)), mk(1, 64'h1008 + 64'(16 * i)));
        end
        chk("full_backpressure", 256'(saw_not_ready), 256'(1));

        // Flush with ten records buffered; afterwards only fresh records appear
        for (int t = 0; t < 40 && model_q.size() > 10; t++) step(0, '0, '0);
        do_reset(1);
        pc_next = 64'h2000_0000;
        step(2, mk(0, '0), mk(0, '0));
        step(1, mk(1, 64'h300), '0);
        step(2, mk(0, '0), mk(0, '0));
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int nl;
            nl = $urandom_range(0, 2);
            step(nl, mk(($urandom_range(0, 2) == 0), {$urandom, $urandom}),
                     mk(($urandom_range(0, 2) == 0), {$urandom, $urandom}));
        end

        step(0, '0, '0);
        for (int t = 0; t < 60 && model_q.size() > 0; t++) step(0, '0, '0);
        @(posedge clock);
        #2;
        chk("drained", 256'(exp_q.size()), 256'(0));
        chk("final_cnt", 256'(io.commit_cnt), 256'(model_cnt));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
